// File: rtl/sdrc_app_arbiter.sv
// Two-requester arbiter for the SDRAM controller application port; at most one transaction in flight.
// Define SDRC_ARB_FIXED_PRIO_EN for fixed priority (rq0 wins ties); the default build is round-robin.
module sdrc_app_arbiter (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        rq0_req,
    input  logic [25:0] rq0_addr,
    input  logic [8:0]  rq0_len,
    input  logic        rq0_wr_n,
    input  logic [31:0] rq0_wr_data,
    input  logic [3:0]  rq0_wr_en_n,
    output logic        rq0_ack,
    output logic        rq0_wr_next,
    output logic        rq0_rd_valid,
    output logic        rq0_last,
    output logic [31:0] rq0_rd_data,
    input  logic        rq1_req,
    input  logic [25:0] rq1_addr,
    input  logic [8:0]  rq1_len,
    input  logic        rq1_wr_n,
    input  logic [31:0] rq1_wr_data,
    input  logic [3:0]  rq1_wr_en_n,
    output logic        rq1_ack,
    output logic        rq1_wr_next,
    output logic        rq1_rd_valid,
    output logic        rq1_last,
    output logic [31:0] rq1_rd_data,
    output logic        app_req,
    output logic [25:0] app_req_addr,
    output logic [8:0]  app_req_len,
    output logic        app_req_wr_n,
    output logic [31:0] app_wr_data,
    output logic [3:0]  app_wr_en_n,
    input  logic        app_req_ack,
    input  logic        app_busy_n,
    input  logic        app_wr_next_req,
    input  logic        app_rd_valid,
    input  logic        app_last_rd,
    input  logic        app_last_wr,
    input  logic [31:0] app_rd_data
);

    typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

    state_t      state_q;
    logic        grant_q;
    logic        app_req_q;
    logic [25:0] addr_q;
    logic [8:0]  len_q;
    logic        wr_n_q;
    logic        grant_d;
    logic        any_req;
    logic        ack_pulse;
    logic        txn_done;

`ifdef SDRC_ARB_FIXED_PRIO_EN
`else
    logic        rr_ptr_q;
`endif

    // Winner for the next grant; a lone requester always wins, ties go by priority mode.
    always_comb begin
        any_req = rq0_req | rq1_req;
        if (rq0_req && rq1_req) begin
`ifdef SDRC_ARB_FIXED_PRIO_EN
            grant_d = 1'b0;
`else
            grant_d = rr_ptr_q;
`endif
        end else begin
            grant_d = rq1_req;
        end
    end

    assign ack_pulse = (state_q == REQ) && app_req_ack;
    assign txn_done  = ((state_q == WDATA) && app_last_wr) || ((state_q == RDATA) && app_last_rd);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            grant_q   <= 1'b0;
            app_req_q <= 1'b0;
            addr_q    <= '0;
            len_q     <= '0;
            wr_n_q    <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req && app_busy_n) begin
                        grant_q   <= grant_d;
                        addr_q    <= grant_d ? rq1_addr : rq0_addr;
                        len_q     <= grant_d ? rq1_len  : rq0_len;
                        wr_n_q    <= grant_d ? rq1_wr_n : rq0_wr_n;
                        app_req_q <= 1'b1;
                        state_q   <= REQ;
                    end
                end
                REQ: begin
                    if (app_req_ack) begin
                        app_req_q <= 1'b0;
                        state_q   <= wr_n_q ? RDATA : WDATA;
                    end
                end
                WDATA: begin
                    if (app_last_wr) state_q <= IDLE;
                end
                RDATA: begin
                    if (app_last_rd) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef SDRC_ARB_FIXED_PRIO_EN
`else
    // The pointer moves only on completion, so the other requester is favoured next.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rr_ptr_q <= 1'b0;
        end else if (txn_done) begin
            rr_ptr_q <= ~grant_q;
        end
    end
`endif

    assign app_req      = app_req_q;
    assign app_req_addr = addr_q;
    assign app_req_len  = len_q;
    assign app_req_wr_n = wr_n_q;

    assign app_wr_data  = grant_q ? rq1_wr_data : rq0_wr_data;
    assign app_wr_en_n  = (state_q == WDATA) ? (grant_q ? rq1_wr_en_n : rq0_wr_en_n) : 4'hF;

    assign rq0_ack      = ack_pulse && !grant_q;
    assign rq1_ack      = ack_pulse &&  grant_q;
    assign rq0_wr_next  = (state_q == WDATA) && app_wr_next_req && !grant_q;
    assign rq1_wr_next  = (state_q == WDATA) && app_wr_next_req &&  grant_q;
    assign rq0_rd_valid = (state_q == RDATA) && app_rd_valid && !grant_q;
    assign rq1_rd_valid = (state_q == RDATA) && app_rd_valid &&  grant_q;
    assign rq0_last     = txn_done && !grant_q;
    assign rq1_last     = txn_done &&  grant_q;

    // Read data is shared; qualification comes from the per-requester rd_valid.
    assign rq0_rd_data  = app_rd_data;
    assign rq1_rd_data  = app_rd_data;

endmodule

// File: tb/tb_sdrc_app_arbiter.sv
// Self-checking bench for sdrc_app_arbiter: transaction-level reference model plus directed scenarios.
// Build with SDRC_ARB_FIXED_PRIO_EN defined to check the fixed-priority variant.
module tb_sdrc_app_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  rqReq = 2'b00;
    logic [1:0]  rqWrN = 2'b11;
    logic [25:0] rqAddr [2];
    logic [8:0]  rqLen [2];
    logic [31:0] rqWrData [2];
    logic [3:0]  rqWrEnN [2];
    wire  [1:0]  rqAck, rqWrNext, rqRdValid, rqLast;
    wire  [31:0] rdData0, rdData1;
    wire         appReq, appReqWrN;
    wire  [25:0] appReqAddr;
    wire  [8:0]  appReqLen;
    wire  [31:0] appWrData;
    wire  [3:0]  appWrEnN;
    logic        appReqAck = 1'b0, appBusyN = 1'b1, appWrNextReq = 1'b0;
    logic        appRdValid = 1'b0, appLastRd = 1'b0, appLastWr = 1'b0;
    logic [31:0] appRdData = '0;

    int total = 0;
    int bad = 0;

    // Reference model: one transaction record (owner, fields, acked) plus the favoured requester.
    bit          mBusy = 1'b0, mAcked = 1'b0, mOwner = 1'b0, mFav = 1'b0;
    logic [25:0] mAddr = '0;
    logic [8:0]  mLen = '0;
    logic        mWrN = 1'b1;

    int cntAppReq = 0;
    int cntAck [2] = '{0, 0};
    int cntWrNext [2] = '{0, 0};
    int cntRdValid [2] = '{0, 0};
    int cntLast [2] = '{0, 0};
    int ackOrder [$];

    always #5 clk = ~clk;

    sdrc_app_arbiter dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .rq0_req(rqReq[0]), .rq0_addr(rqAddr[0]), .rq0_len(rqLen[0]), .rq0_wr_n(rqWrN[0]),
        .rq0_wr_data(rqWrData[0]), .rq0_wr_en_n(rqWrEnN[0]),
        .rq0_ack(rqAck[0]), .rq0_wr_next(rqWrNext[0]), .rq0_rd_valid(rqRdValid[0]),
        .rq0_last(rqLast[0]), .rq0_rd_data(rdData0),
        .rq1_req(rqReq[1]), .rq1_addr(rqAddr[1]), .rq1_len(rqLen[1]), .rq1_wr_n(rqWrN[1]),
        .rq1_wr_data(rqWrData[1]), .rq1_wr_en_n(rqWrEnN[1]),
        .rq1_ack(rqAck[1]), .rq1_wr_next(rqWrNext[1]), .rq1_rd_valid(rqRdValid[1]),
        .rq1_last(rqLast[1]), .rq1_rd_data(rdData1),
        .app_req(appReq), .app_req_addr(appReqAddr), .app_req_len(appReqLen),
        .app_req_wr_n(appReqWrN), .app_wr_data(appWrData), .app_wr_en_n(appWrEnN),
        .app_req_ack(appReqAck), .app_busy_n(appBusyN), .app_wr_next_req(appWrNextReq),
        .app_rd_valid(appRdValid), .app_last_rd(appLastRd), .app_last_wr(appLastWr),
        .app_rd_data(appRdData)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model by what the next edge will see.
    always @(negedge clk) begin
        bit [1:0]   eAck, eWrNext, eRdValid, eLast;
        bit         eReq, inWr, inRd, w;
        logic [3:0] eEn;
        if (rst) begin
            mBusy = 1'b0; mAcked = 1'b0; mOwner = 1'b0; mFav = 1'b0;
            mAddr = '0; mLen = '0; mWrN = 1'b1;
        end
        eAck = '0; eWrNext = '0; eRdValid = '0; eLast = '0;
        eReq = mBusy && !mAcked;
        inWr = mBusy && mAcked && !mWrN;
        inRd = mBusy && mAcked && mWrN;
        eAck[mOwner]     = eReq && appReqAck;
        eWrNext[mOwner]  = inWr && appWrNextReq;
        eRdValid[mOwner] = inRd && appRdValid;
        eLast[mOwner]    = (inWr && appLastWr) || (inRd && appLastRd);
        eEn = inWr ? rqWrEnN[mOwner] : 4'hF;

        checkOutput("app_req", 32'(appReq), 32'(eReq));
        checkOutput("app_req_addr", 32'(appReqAddr), 32'(mAddr));
        checkOutput("app_req_len", 32'(appReqLen), 32'(mLen));
        checkOutput("app_req_wr_n", 32'(appReqWrN), 32'(mWrN));
        checkOutput("app_wr_en_n", 32'(appWrEnN), 32'(eEn));
        checkOutput("rq_ack", 32'(rqAck), 32'(eAck));
        checkOutput("rq_wr_next", 32'(rqWrNext), 32'(eWrNext));
        checkOutput("rq_rd_valid", 32'(rqRdValid), 32'(eRdValid));
        checkOutput("rq_last", 32'(rqLast), 32'(eLast));
        checkOutput("rq0_rd_data", rdData0, appRdData);
        checkOutput("rq1_rd_data", rdData1, appRdData);
        if (inWr) checkOutput("app_wr_data", appWrData, rqWrData[mOwner]);

        if (appReq) cntAppReq++;
        for (int n = 0; n < 2; n++) begin
            if (rqAck[n]) begin
                cntAck[n]++;
                ackOrder.push_back(n);
            end
            if (rqWrNext[n]) cntWrNext[n]++;
            if (rqRdValid[n]) cntRdValid[n]++;
            if (rqLast[n]) cntLast[n]++;
        end

        if (!rst) begin
            if (!mBusy) begin
                if (appBusyN && (rqReq != 2'b00)) begin
                    if (rqReq == 2'b11) begin
`ifdef SDRC_ARB_FIXED_PRIO_EN
                        w = 1'b0;
`else
                        w = mFav;
`endif
                    end else begin
                        w = rqReq[1];
                    end
                    mBusy = 1'b1; mAcked = 1'b0; mOwner = w;
                    mAddr = rqAddr[w]; mLen = rqLen[w]; mWrN = rqWrN[w];
                end
            end else if (!mAcked) begin
                if (appReqAck) mAcked = 1'b1;
            end else if (eLast != 2'b00) begin
                mBusy = 1'b0;
                mFav  = !mOwner;
            end
        end
    end

    // Advance one cycle; a requester drops its request once its transaction has been accepted.
    task automatic step();
        @(posedge clk);
        #1;
        for (int n = 0; n < 2; n++)
            if (mBusy && mAcked && (mOwner == 1'(n))) rqReq[n] = 1'b0;
    endtask

    task automatic idleCtrl();
        appReqAck = 1'b0; appBusyN = 1'b1; appWrNextReq = 1'b0;
        appRdValid = 1'b0; appLastRd = 1'b0; appLastWr = 1'b0;
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic drain();
        rqReq = 2'b00;
        repeat (6) begin
            step();
            rqReq = 2'b00;
            appReqAck = 1'b1; appLastRd = 1'b1; appLastWr = 1'b1;
            appRdValid = 1'b0; appWrNextReq = 1'b0;
        end
        idleCtrl();
        step();
    endtask

    // One cycle of random controller behaviour and requester traffic, with rare resets.
    task automatic applyStimulus();
        step();
        appReqAck    = ($urandom % 3) == 0;
        appBusyN     = ($urandom % 8) != 0;
        appWrNextReq = 1'($urandom);
        appRdValid   = 1'($urandom);
        appLastWr    = ($urandom % 6) == 0;
        appLastRd    = ($urandom % 6) == 0;
        appRdData    = $urandom;
        for (int n = 0; n < 2; n++) begin
            rqWrData[n] = $urandom;
            rqWrEnN[n]  = 4'($urandom);
            if (!rqReq[n] && !(mBusy && (mOwner == 1'(n))) && (($urandom % 3) == 0)) begin
                rqReq[n]  = 1'b1;
                rqAddr[n] = 26'($urandom);
                rqLen[n]  = 9'($urandom);
                rqWrN[n]  = 1'($urandom);
            end
        end
        rst = ($urandom % 300) == 0;
    endtask

    initial begin
        int base, baseB, baseC, baseD, baseE, baseF;
        int expOrder [4];
`ifdef SDRC_ARB_FIXED_PRIO_EN
        expOrder = '{0, 0, 0, 0};
`else
        expOrder = '{0, 1, 0, 1};
`endif
        for (int n = 0; n < 2; n++) begin
            rqAddr[n] = '0; rqLen[n] = '0; rqWrData[n] = '0; rqWrEnN[n] = 4'hF;
        end
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_app_req", 32'(appReq), 32'h0);
        checkOutput("reset_app_req_wr_n", 32'(appReqWrN), 32'h1);
        checkOutput("reset_app_wr_en_n", 32'(appWrEnN), 32'hF);
        rst = 1'b0;

        // Single rq0 write: ack on the third app_req cycle, four write beats.
        step();
        base = cntAppReq; baseB = cntAck[0]; baseC = cntWrNext[0]; baseD = cntLast[0];
        baseE = cntAck[1] + cntWrNext[1] + cntRdValid[1] + cntLast[1];
        rqReq[0] = 1'b1; rqAddr[0] = 26'h000100; rqLen[0] = 9'd4; rqWrN[0] = 1'b0;
        rqWrEnN[0] = 4'h3; rqWrData[0] = 32'hCAFE0001;
        step();
        checkOutput("wr_addr_latched", 32'(appReqAddr), 32'h100);
        step();
        step();
        appReqAck = 1'b1;
        step();
        appReqAck = 1'b0; appWrNextReq = 1'b1;
        checkOutput("wr_en_mux", 32'(appWrEnN), 32'h3);
        step();
        step();
        step();
        appLastWr = 1'b1;
        step();
        idleCtrl();
        step();
        checkOutput("wr_app_req_cycles", 32'(cntAppReq - base), 32'd3);
        checkOutput("wr_rq0_ack_count", 32'(cntAck[0] - baseB), 32'd1);
        checkOutput("wr_rq0_wr_next_count", 32'(cntWrNext[0] - baseC), 32'd4);
        checkOutput("wr_rq0_last_count", 32'(cntLast[0] - baseD), 32'd1);
        checkOutput("wr_rq1_quiet", 32'(cntAck[1] + cntWrNext[1] + cntRdValid[1] + cntLast[1] - baseE), 32'd0);

        // Both requesters read continuously from the same cycle; record grant order.
        resetPulse();
        base = ackOrder.size();
        for (int n = 0; n < 2; n++) begin
            rqReq[n] = 1'b1; rqWrN[n] = 1'b1; rqLen[n] = 9'd4; rqAddr[n] = 26'(n * 64);
        end
        for (int c = 0; c < 400 && ackOrder.size() < base + 4; c++) begin
            step();
            appReqAck = 1'($urandom); appRdValid = 1'($urandom); appLastRd = ($urandom % 3) == 0;
            for (int n = 0; n < 2; n++)
                if (!rqReq[n] && !(mBusy && (mOwner == 1'(n)))) rqReq[n] = 1'b1;
        end
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("grant_order%0d", i),
                        (base + i < ackOrder.size()) ? 32'(ackOrder[base + i]) : 32'd99, 32'(expOrder[i]));
        drain();

        // Controller busy: request must wait, then app_req rises one cycle after busy clears.
        step();
        appBusyN = 1'b0;
        rqReq[1] = 1'b1; rqWrN[1] = 1'b1; rqLen[1] = 9'd1; rqAddr[1] = 26'h3;
        repeat (10) begin
            step();
            checkOutput("busy_no_req", 32'(appReq), 32'h0);
        end
        appBusyN = 1'b1;
        step();
        checkOutput("busy_release_req", 32'(appReq), 32'h1);
        appReqAck = 1'b1;
        step();
        appReqAck = 1'b0; appLastRd = 1'b1;
        step();
        idleCtrl();
        step();

        // Reset in the middle of an 8-beat rq0 read, then a clean rq1 read.
        base = cntLast[0];
        rqReq[0] = 1'b1; rqWrN[0] = 1'b1; rqLen[0] = 9'd8; rqAddr[0] = 26'h2AA;
        step();
        appReqAck = 1'b1;
        step();
        appReqAck = 1'b0; appRdValid = 1'b1;
        step();
        step();
        rst = 1'b1;
        #1;
        checkOutput("rst_rd_valid", 32'(rqRdValid), 32'h0);
        checkOutput("rst_addr", 32'(appReqAddr), 32'h0);
        checkOutput("rst_wr_n", 32'(appReqWrN), 32'h1);
        checkOutput("rst_wr_en_n", 32'(appWrEnN), 32'hF);
        rqReq[0] = 1'b0;
        appRdValid = 1'b0;
        step();
        rst = 1'b0;
        baseB = cntLast[1]; baseC = cntRdValid[1]; baseD = cntAck[1];
        step();
        rqReq[1] = 1'b1; rqWrN[1] = 1'b1; rqLen[1] = 9'd2; rqAddr[1] = 26'h40;
        appReqAck = 1'b1;
        step();
        step();
        appReqAck = 1'b0; appRdValid = 1'b1;
        step();
        appLastRd = 1'b1;
        step();
        idleCtrl();
        step();
        checkOutput("rst_no_rq0_last", 32'(cntLast[0] - base), 32'd0);
        checkOutput("after_rst_rq1_ack", 32'(cntAck[1] - baseD), 32'd1);
        checkOutput("after_rst_rq1_beats", 32'(cntRdValid[1] - baseC), 32'd2);
        checkOutput("after_rst_rq1_last", 32'(cntLast[1] - baseB), 32'd1);

        // Spurious read-valid while idle and during a write.
        baseE = cntRdValid[0] + cntRdValid[1];
        appRdValid = 1'b1;
        repeat (3) begin
            step();
            checkOutput("spurious_idle_req", 32'(appReq), 32'h0);
        end
        baseF = cntLast[0];
        rqReq[0] = 1'b1; rqWrN[0] = 1'b0; rqLen[0] = 9'd2; rqWrEnN[0] = 4'h0;
        appReqAck = 1'b1;
        step();
        step();
        appReqAck = 1'b0; appWrNextReq = 1'b1;
        step();
        appLastWr = 1'b1;
        step();
        idleCtrl();
        step();
        checkOutput("spurious_rd_valid", 32'(cntRdValid[0] + cntRdValid[1] - baseE), 32'd0);
        checkOutput("spurious_wr_last", 32'(cntLast[0] - baseF), 32'd1);

        // Random traffic checked cycle by cycle against the model.
        repeat (3000) applyStimulus();
        rst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
